// File: rtl/dataset_sequencer.sv
// Walks the train/test sample regions of feature memory and streams feature addresses to the encoder.
// Optional stall counter enabled by defining DATASET_SEQ_STALL_CNT_EN.
module dataset_sequencer #(
    parameter int unsigned NUM_TRAIN    = 60,
    parameter int unsigned NUM_TEST     = 20,
    parameter int unsigned NUM_FEATURES = 784,
    parameter int unsigned TRAIN_BASE   = 0,
    parameter int unsigned TEST_BASE    = 47040,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              training_hdc_model,
    input  logic              testing_hdc_model,
    output logic              feat_valid,
    input  logic              feat_ready,
    output logic [ADDR_W-1:0] feat_addr,
    output logic              feat_last,
    output logic [CNT_W-1:0]  sample_idx,
    input  logic              sample_encoded,
    output logic              training_dataset_finished,
    output logic              testing_dataset_finished,
    output logic [31:0]       stall_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_FINISH,
        S_HOLD
    } state_t;

    localparam logic [ADDR_W-1:0] TRAIN_BASE_A = ADDR_W'(TRAIN_BASE);
    localparam logic [ADDR_W-1:0] TEST_BASE_A  = ADDR_W'(TEST_BASE);
    localparam logic [CNT_W-1:0]  LAST_FEAT    = CNT_W'(NUM_FEATURES - 1);
    localparam logic [CNT_W-1:0]  TRAIN_LAST   = CNT_W'(NUM_TRAIN - 1);
    localparam logic [CNT_W-1:0]  TEST_LAST    = CNT_W'(NUM_TEST - 1);

    state_t            state, state_n;
    logic              sel_test, sel_test_n;
    logic [CNT_W-1:0]  feat_idx, feat_idx_n;
    logic [CNT_W-1:0]  sample_idx_n;
    logic [ADDR_W-1:0] feat_addr_n;
    logic              feat_valid_n, feat_last_n;
    logic              train_fin_n, test_fin_n;
    logic              mode_train, mode_test, act_ok, xfer, last_sample;

    assign mode_train  = training_hdc_model && !testing_hdc_model;
    assign mode_test   = testing_hdc_model && !training_hdc_model;
    assign act_ok      = sel_test ? mode_test : mode_train;
    assign xfer        = en && feat_valid && feat_ready;
    assign last_sample = sample_idx == (sel_test ? TEST_LAST : TRAIN_LAST);

    // Next-state and next-output logic; abort on a lost or illegal mode wins over handshakes
    always_comb begin
        state_n      = state;
        sel_test_n   = sel_test;
        feat_idx_n   = feat_idx;
        sample_idx_n = sample_idx;
        feat_addr_n  = feat_addr;
        feat_valid_n = feat_valid;
        train_fin_n  = 1'b0;
        test_fin_n   = 1'b0;
        unique case (state)
            S_IDLE: begin
                feat_valid_n = 1'b0;
                feat_idx_n   = '0;
                sample_idx_n = '0;
                feat_addr_n  = '0;
                if (en && (mode_train || mode_test)) begin
                    sel_test_n   = mode_test;
                    feat_addr_n  = mode_test ? TEST_BASE_A : TRAIN_BASE_A;
                    feat_valid_n = 1'b1;
                    state_n      = S_FEED;
                end
            end
            S_FEED: begin
                if (en && !act_ok) begin
                    state_n      = S_IDLE;
                    feat_valid_n = 1'b0;
                    feat_idx_n   = '0;
                    sample_idx_n = '0;
                    feat_addr_n  = '0;
                end else if (xfer) begin
                    feat_addr_n = feat_addr + ADDR_W'(1);
                    feat_idx_n  = feat_idx + CNT_W'(1);
                    if (feat_last) begin
                        feat_valid_n = 1'b0;
                        state_n      = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (en && !act_ok) begin
                    state_n      = S_IDLE;
                    feat_valid_n = 1'b0;
                    feat_idx_n   = '0;
                    sample_idx_n = '0;
                    feat_addr_n  = '0;
                end else if (en && sample_encoded) begin
                    if (last_sample) begin
                        state_n     = S_FINISH;
                        train_fin_n = !sel_test;
                        test_fin_n  = sel_test;
                    end else begin
                        sample_idx_n = sample_idx + CNT_W'(1);
                        feat_idx_n   = '0;
                        feat_valid_n = 1'b1;
                        state_n      = S_FEED;
                    end
                end
            end
            S_FINISH: begin
                state_n = S_HOLD;
            end
            S_HOLD: begin
                if (en && !act_ok) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        feat_last_n = (state_n == S_FEED) && (feat_idx_n == LAST_FEAT);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state                     <= S_IDLE;
            sel_test                  <= 1'b0;
            feat_idx                  <= '0;
            sample_idx                <= '0;
            feat_addr                 <= '0;
            feat_valid                <= 1'b0;
            feat_last                 <= 1'b0;
            training_dataset_finished <= 1'b0;
            testing_dataset_finished  <= 1'b0;
        end else begin
            state                     <= state_n;
            sel_test                  <= sel_test_n;
            feat_idx                  <= feat_idx_n;
            sample_idx                <= sample_idx_n;
            feat_addr                 <= feat_addr_n;
            feat_valid                <= feat_valid_n;
            feat_last                 <= feat_last_n;
            training_dataset_finished <= train_fin_n;
            testing_dataset_finished  <= test_fin_n;
        end
    end

`ifdef DATASET_SEQ_STALL_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of cycles the encoder holds off a valid feature
    always_ff @(posedge clk) begin
        if (!nrst) begin
            stall_q <= '0;
        end else if (state != S_IDLE && state_n == S_IDLE) begin
            stall_q <= '0;
        end else if (feat_valid && !feat_ready && en && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dataset_sequencer.sv
// Self-checking bench for dataset_sequencer: vector table plus scoreboarded passes.
// Small configuration: 3 train, 2 test samples of 4 features.
module tb_dataset_sequencer;

    logic        clk;
    logic        nrst;
    logic        en;
    logic        training_hdc_model;
    logic        testing_hdc_model;
    logic        feat_valid;
    logic        feat_ready;
    logic [15:0] feat_addr;
    logic        feat_last;
    logic [15:0] sample_idx;
    logic        sample_encoded;
    logic        training_dataset_finished;
    logic        testing_dataset_finished;
    logic [31:0] stall_cycles;

    dataset_sequencer #(
        .NUM_TRAIN(3),
        .NUM_TEST(2),
        .NUM_FEATURES(4),
        .TRAIN_BASE(0),
        .TEST_BASE('h100),
        .ADDR_W(16),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .en(en),
        .training_hdc_model(training_hdc_model),
        .testing_hdc_model(testing_hdc_model),
        .feat_valid(feat_valid),
        .feat_ready(feat_ready),
        .feat_addr(feat_addr),
        .feat_last(feat_last),
        .sample_idx(sample_idx),
        .sample_encoded(sample_encoded),
        .training_dataset_finished(training_dataset_finished),
        .testing_dataset_finished(testing_dataset_finished),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DATASET_SEQ_STALL_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd5;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    typedef struct {
        logic        nrst, en, tr, te, rdy, se;
        logic        v, last;
        logic [15:0] addr, sidx;
    } vec_t;

    vec_t        vecs[15];
    logic [31:0] sbq[$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          tr_fin  = 0;
    int          te_fin  = 0;
    int          enc_cnt = 0;
    bit          sb_on   = 0;
    bit          auto_enc = 0;
    bit          cur_test = 0;
    bit          seen_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic bit mode_ok();
        return cur_test ? (testing_hdc_model && !training_hdc_model)
                        : (training_hdc_model && !testing_hdc_model);
    endfunction

    // One clock: model a transfer, run the encoder model, advance, sample #1 after the edge
    task automatic tick();
        bit x;
        logic [31:0] exp;
        x = sb_on && nrst && en && feat_valid && feat_ready && mode_ok();
        if (auto_enc) sample_encoded = (enc_cnt == 1);
        if (enc_cnt > 0) enc_cnt--;
        if (x) begin
            if (sbq.size() == 0) begin
                chk("unexpected_xfer", {16'd0, feat_addr}, 32'hFFFF_FFFF);
            end else begin
                exp = sbq.pop_front();
                chk("xfer", {feat_last, sample_idx[14:0], feat_addr}, exp);
            end
            if (feat_last && auto_enc) enc_cnt = 3;
        end
        @(posedge clk);
        #1;
        if (training_dataset_finished) tr_fin++;
        if (testing_dataset_finished) te_fin++;
    endtask

    task automatic push_pass(input int base, input int ns, input int nf_limit);
        int n = 0;
        for (int s = 0; s < ns; s++) begin
            for (int f = 0; f < 4; f++) begin
                if (n < nf_limit) begin
                    sbq.push_back({f == 3, 15'(s), 16'(base + s * 4 + f)});
                end
                n++;
            end
        end
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
    endtask

    task automatic wait_addr(input logic [15:0] a);
        int i;
        for (i = 0; i < 100; i++) begin
            if (feat_valid && feat_addr == a) break;
            tick();
        end
        if (i == 100) chk("timeout_addr", {16'd0, feat_addr}, {16'd0, a});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; en = 1'b1;
        training_hdc_model = 1'b0; testing_hdc_model = 1'b0;
        feat_ready = 1'b0; sample_encoded = 1'b0;

        //            nrst  en    tr    te    rdy   se    v     last  addr      sidx
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000, 16'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h000, 16'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h000, 16'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h000, 16'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h001, 16'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h001, 16'd0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h002, 16'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h003, 16'd0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h000, 16'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h004, 16'd1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h000, 16'd0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h000, 16'd0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h000, 16'd0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h100, 16'd0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000, 16'd0};

        for (int i = 0; i < 15; i++) begin
            nrst = vecs[i].nrst; en = vecs[i].en;
            training_hdc_model = vecs[i].tr; testing_hdc_model = vecs[i].te;
            feat_ready = vecs[i].rdy; sample_encoded = vecs[i].se;
            tick();
            chk($sformatf("vec%0d", i),
                {feat_valid, feat_last, training_dataset_finished,
                 testing_dataset_finished, sample_idx[11:0],
                 (vecs[i].v ? feat_addr : 16'h000)},
                {vecs[i].v, vecs[i].last, 2'b00, vecs[i].sidx[11:0], vecs[i].addr});
            if (i == 0) chk("reset_stall", stall_cycles, 32'd0);
        end

        // Full training pass, then immediate switch to testing
        sample_encoded = 1'b0; feat_ready = 1'b1; en = 1'b1;
        training_hdc_model = 1'b0; testing_hdc_model = 1'b0;
        do_reset();
        tr_fin = 0; te_fin = 0;
        cur_test = 0; auto_enc = 1; sb_on = 1;
        push_pass('h000, 3, 12);
        training_hdc_model = 1'b1;
        for (int i = 0; i < 300 && tr_fin == 0; i++) tick();
        chk("train_fin_seen", tr_fin, 1);
        chk("train_sb_empty", sbq.size(), 0);
        training_hdc_model = 1'b0; testing_hdc_model = 1'b1; cur_test = 1;
        push_pass('h100, 2, 8);
        tick();
        chk("train_fin_1cyc", tr_fin, 1);
        chk("test_lat_c1", feat_valid, 0);
        tick();
        chk("test_lat_c2", feat_valid, 0);
        for (int i = 0; i < 300 && te_fin == 0; i++) tick();
        chk("test_fin_seen", te_fin, 1);
        chk("test_sb_empty", sbq.size(), 0);
        seen_v = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (feat_valid) seen_v = 1;
        end
        chk("hold_no_rerun", seen_v, 0);
        chk("fin_counts", {tr_fin[15:0], te_fin[15:0]}, {16'd1, 16'd1});

        // Backpressure, en gating, abort and restart
        testing_hdc_model = 1'b0; sb_on = 0;
        do_reset();
        cur_test = 0; sb_on = 1; enc_cnt = 0;
        push_pass('h000, 2, 5);
        training_hdc_model = 1'b1;
        wait_addr(16'h002);
        feat_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", {15'd0, feat_valid, feat_addr}, {15'd0, 1'b1, 16'h002});
        end
        chk("bp_stall", stall_cycles, EXP_STALL);
        feat_ready = 1'b1; en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("en_freeze", {15'd0, feat_valid, feat_addr}, {15'd0, 1'b1, 16'h002});
        en = 1'b1;
        wait_addr(16'h005);
        chk("abort_at_s1", sample_idx, 1);
        training_hdc_model = 1'b0;
        tick();
        chk("abort_out", {15'd0, feat_valid, sample_idx}, 32'd0);
        chk("abort_sb_empty", sbq.size(), 0);
        chk("abort_stall_clr", stall_cycles, 32'd0);
        sb_on = 0;
        training_hdc_model = 1'b1;
        tick();
        chk("restart", {15'd0, feat_valid, feat_addr}, {15'd0, 1'b1, 16'h000});

        // Synchronous reset while waiting for the encoder
        auto_enc = 0; sample_encoded = 1'b0;
        wait_addr(16'h003);
        tick();
        chk("in_wait", {15'd0, feat_valid, feat_addr}, {15'd0, 1'b0, 16'h004});
        nrst = 1'b0;
        tick();
        chk("rst_outs",
            {feat_valid, feat_last, training_dataset_finished,
             testing_dataset_finished, sample_idx[11:0], feat_addr},
            32'd0);
        chk("rst_stall", stall_cycles, 32'd0);
        nrst = 1'b1;
        training_hdc_model = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
